// File: rtl/ptp_bridge_igr_pkt_arb_if.sv
// ptp_bridge_igr_pkt_arb_if: requester-side and HSSI-side AXI-S bundle for the ingress arbiter
interface ptp_bridge_igr_pkt_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] s_tvalid;
  logic [NUM_REQ-1:0] s_tready;
  logic [NUM_REQ-1:0] s_tlast;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_tkeep;
  logic m_tvalid;
  logic m_tready;
  logic m_tlast;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic [DATA_WIDTH/8-1:0] m_tkeep;
  logic [IDW-1:0] m_tid;
  logic [NUM_REQ-1:0] arb_grant;
  logic arb_busy;
  modport master (
    input s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, arb_grant, arb_busy
  );
  modport slave (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    input s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, arb_grant, arb_busy
  );
endinterface

// File: rtl/ptp_bridge_igr_pkt_arb.sv
// ptp_bridge_igr_pkt_arb: packet-granular round-robin ingress arbiter with registered output stage
module ptp_bridge_igr_pkt_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_PRIO = 0,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int KW = DATA_WIDTH / 8
) (
  input logic clk,
  input logic rst,
  ptp_bridge_igr_pkt_arb_if.master bus
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] last_q, last_d, win, tid_q, tid_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic vld_q, vld_d, lst_q, lst_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [KW-1:0] kep_q, kep_d;
  logic found, pipe_rdy, acc;
  // last_q doubles as the granted index while in XFER
  always_comb begin
    win = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.s_tvalid[(int'(last_q) + k) % NUM_REQ]) begin
        win = IDW'((int'(last_q) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
    if (USER_PRIO != 0 && bus.s_tvalid[0]) win = '0;
  end
  assign pipe_rdy = !vld_q || bus.m_tready;
  assign acc = state_q == XFER && pipe_rdy && bus.s_tvalid[last_q];
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gnt_d = gnt_q;
    vld_d = acc ? 1'b1 : (bus.m_tready ? 1'b0 : vld_q);
    dat_d = acc ? bus.s_tdata[last_q*DATA_WIDTH +: DATA_WIDTH] : dat_q;
    kep_d = acc ? bus.s_tkeep[last_q*KW +: KW] : kep_q;
    lst_d = acc ? bus.s_tlast[last_q] : lst_q;
    tid_d = acc ? last_q : tid_q;
    if (state_q == IDLE && |bus.s_tvalid) begin
      state_d = XFER;
      last_d = win;
      gnt_d = NUM_REQ'(1) << win;
    end else if (acc && bus.s_tlast[last_q]) begin
      state_d = IDLE;
      gnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IDW'(NUM_REQ - 1);
      gnt_q <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
      kep_q <= '0;
      lst_q <= 1'b0;
      tid_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
      kep_q <= kep_d;
      lst_q <= lst_d;
      tid_q <= tid_d;
    end
  end
  assign bus.s_tready = (state_q == XFER && pipe_rdy) ? NUM_REQ'(1) << last_q : '0;
  assign bus.m_tvalid = vld_q;
  assign bus.m_tdata = dat_q;
  assign bus.m_tkeep = kep_q;
  assign bus.m_tlast = lst_q;
  assign bus.m_tid = tid_q;
  assign bus.arb_grant = gnt_q;
  assign bus.arb_busy = state_q == XFER;
endmodule

// File: tb/tb_ptp_bridge_igr_pkt_arb.sv
// tb_ptp_bridge_igr_pkt_arb: directed checks of the ingress arbiter, round-robin and user-priority builds
module tb_ptp_bridge_igr_pkt_arb;
  localparam int N = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  typedef struct packed {
    logic [1:0] tid;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic last;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_v = 1'b1;
  logic en [2][N];
  int len [2][N];
  int bc [2][N];
  int pc [2][N];
  logic mrdy [2];
  beat_t q0[$];
  beat_t q1[$];
  beat_t snap0;
  logic stall0 = 1'b0;
  int stable_err = 0;
  int passed = 0;
  int total = 0;

  ptp_bridge_igr_pkt_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) u0 ();
  ptp_bridge_igr_pkt_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) u1 ();
  ptp_bridge_igr_pkt_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .USER_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(u0));
  ptp_bridge_igr_pkt_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .USER_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(u1));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkd(int i, int p, int b);
    return {32'(i), 16'(p), 16'(b)};
  endfunction
  function automatic logic [KW-1:0] mkk(int i, int b);
    return {4'(i), 4'(b)};
  endfunction
  function automatic beat_t exb(int i, int p, int b, logic l);
    return {2'(i), mkd(i, p, b), mkk(i, b), l};
  endfunction

  task automatic adv(input int d, input int i);
    if (bc[d][i] == len[d][i] - 1) begin
      bc[d][i] = 0;
      pc[d][i]++;
    end else bc[d][i]++;
  endtask

  // drive at negedge, log handshakes just before posedge, return 1 time unit after posedge
  task automatic cyc();
    logic [N-1:0] v0, v1, l0, l1;
    logic [N*DW-1:0] d0, d1;
    logic [N*KW-1:0] k0, k1;
    beat_t b;
    @(negedge clk);
    rst = rst_v;
    for (int i = 0; i < N; i++) begin
      v0[i] = en[0][i];
      l0[i] = bc[0][i] == len[0][i] - 1;
      d0[i*DW +: DW] = mkd(i, pc[0][i], bc[0][i]);
      k0[i*KW +: KW] = mkk(i, bc[0][i]);
      v1[i] = en[1][i];
      l1[i] = bc[1][i] == len[1][i] - 1;
      d1[i*DW +: DW] = mkd(i, pc[1][i], bc[1][i]);
      k1[i*KW +: KW] = mkk(i, bc[1][i]);
    end
    u0.s_tvalid = v0; u0.s_tlast = l0; u0.s_tdata = d0; u0.s_tkeep = k0; u0.m_tready = mrdy[0];
    u1.s_tvalid = v1; u1.s_tlast = l1; u1.s_tdata = d1; u1.s_tkeep = k1; u1.m_tready = mrdy[1];
    #1;
    b = {u0.m_tid, u0.m_tdata, u0.m_tkeep, u0.m_tlast};
    if (!rst_v) begin
      for (int i = 0; i < N; i++) begin
        if (u0.s_tvalid[i] && u0.s_tready[i]) adv(0, i);
        if (u1.s_tvalid[i] && u1.s_tready[i]) adv(1, i);
      end
      if (u0.m_tvalid && u0.m_tready) q0.push_back(b);
      if (u1.m_tvalid && u1.m_tready) q1.push_back({u1.m_tid, u1.m_tdata, u1.m_tkeep, u1.m_tlast});
      if (stall0 && b != snap0) stable_err++;
      stall0 = u0.m_tvalid && !u0.m_tready;
    end else stall0 = 1'b0;
    snap0 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mrdy[d] = 1'b1;
      for (int i = 0; i < N; i++) begin
        en[d][i] = 1'b0;
        len[d][i] = 1;
      end
    end
    cyc();
    cyc();
    rst_v = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        bc[d][i] = 0;
        pc[d][i] = 0;
      end
    q0.delete();
    q1.delete();
    stable_err = 0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      mrdy[d] = 1'b1;
      for (int i = 0; i < N; i++) begin
        en[d][i] = (d == 0);
        len[d][i] = 3;
        bc[d][i] = 0;
        pc[d][i] = 0;
      end
    end
    rst_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (u0.m_tvalid !== 1'b0 || u0.s_tready !== 4'b0 || u0.arb_grant !== 4'b0)
        $display("FAIL reset_hold%0d mv=%b srdy=%b gnt=%b exp 0/0000/0000", k, u0.m_tvalid, u0.s_tready, u0.arb_grant);
      else passed++;
    end
    rst_v = 1'b0;
    cyc();
    total++;
    if (u0.arb_grant !== 4'b0001 || u0.arb_busy !== 1'b1)
      $display("FAIL reset_first_grant gnt=%b busy=%b exp 0001/1", u0.arb_grant, u0.arb_busy);
    else passed++;
  endtask

  task automatic test_rr();
    for (int c = 0; c < 80 && q0.size() < 12; c++) cyc();
    for (int k = 0; k < 12; k++) begin
      total++;
      if (k >= q0.size() || q0[k] !== exb(k / 3, 0, k % 3, k % 3 == 2))
        $display("FAIL rr_beat%0d got %h exp %h", k, k < q0.size() ? q0[k] : '0, exb(k / 3, 0, k % 3, k % 3 == 2));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en[0][2] = 1'b1;
    len[0][2] = 5;
    for (int c = 0; c < 60 && q0.size() < 5; c++) begin
      mrdy[0] = (c % 2 == 0);
      cyc();
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (k >= q0.size() || q0[k] !== exb(2, 0, k, k == 4))
        $display("FAIL bp_beat%0d got %h exp %h", k, k < q0.size() ? q0[k] : '0, exb(2, 0, k, k == 4));
      else passed++;
    end
    total++;
    if (stable_err !== 0) $display("FAIL bp_stable changes=%0d exp 0", stable_err);
    else passed++;
  endtask

  task automatic test_user_prio();
    beat_t e;
    do_reset();
    en[1][2] = 1'b1;
    len[1][2] = 4;
    cyc();
    total++;
    if (u1.arb_grant !== 4'b0100) $display("FAIL prio_first_grant got %b exp 0100", u1.arb_grant);
    else passed++;
    en[1][0] = 1'b1;
    en[1][1] = 1'b1;
    len[1][0] = 2;
    len[1][1] = 2;
    for (int c = 0; c < 100 && q1.size() < 10; c++) begin
      if (pc[1][0] == 2) en[1][0] = 1'b0;
      cyc();
    end
    for (int k = 0; k < 10; k++) begin
      e = k < 4 ? exb(2, 0, k, k == 3) : k < 8 ? exb(0, (k - 4) / 2, k % 2, k % 2 == 1) : exb(1, 0, k - 8, k == 9);
      total++;
      if (k >= q1.size() || q1[k] !== e)
        $display("FAIL prio_beat%0d got %h exp %h", k, k < q1.size() ? q1[k] : '0, e);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int lasts;
    do_reset();
    en[0][1] = 1'b1;
    len[0][1] = 4;
    for (int c = 0; c < 20 && bc[0][1] < 2; c++) cyc();
    rst_v = 1'b1;
    cyc();
    total++;
    if (u0.m_tvalid !== 1'b0 || u0.arb_grant !== 4'b0 || u0.arb_busy !== 1'b0)
      $display("FAIL midrst_clear mv=%b gnt=%b busy=%b exp 0/0000/0", u0.m_tvalid, u0.arb_grant, u0.arb_busy);
    else passed++;
    lasts = 0;
    foreach (q0[k]) if (q0[k].last) lasts++;
    total++;
    if (lasts !== 0 || bc[0][1] !== 2) $display("FAIL midrst_partial tlasts=%0d beats=%0d exp 0/2", lasts, bc[0][1]);
    else passed++;
    rst_v = 1'b0;
    q0.delete();
    en[0][0] = 1'b1;
    len[0][0] = 1;
    cyc();
    total++;
    if (u0.arb_grant !== 4'b0001) $display("FAIL midrst_regrant got %b exp 0001", u0.arb_grant);
    else passed++;
    for (int c = 0; c < 20 && q0.size() < 1; c++) cyc();
    total++;
    if (q0.size() < 1 || q0[0] !== exb(0, 0, 0, 1'b1))
      $display("FAIL midrst_first_beat got %h exp %h", q0.size() > 0 ? q0[0] : '0, exb(0, 0, 0, 1'b1));
    else passed++;
  endtask

  task automatic test_single_beat();
    logic [N-1:0] eg;
    do_reset();
    en[0][3] = 1'b1;
    len[0][3] = 1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      eg = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      total++;
      if (u0.arb_grant !== eg || u0.m_tvalid !== (k % 2 == 1) || (u0.m_tvalid && u0.m_tid !== 2'd3))
        $display("FAIL single_cyc%0d gnt=%b mv=%b tid=%0d exp %b/%b/3", k, u0.arb_grant, u0.m_tvalid, u0.m_tid, eg, k % 2 == 1);
      else passed++;
    end
    total++;
    if (q0.size() < 2 || q0[1] !== exb(3, 1, 0, 1'b1))
      $display("FAIL single_second_pkt got %h exp %h", q0.size() > 1 ? q0[1] : '0, exb(3, 1, 0, 1'b1));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_backpressure();
    test_user_prio();
    test_mid_reset();
    test_single_beat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
